// File: rtl/int_seq.sv
// int_seq: 6502 interrupt/reset controller. It synchronises NMI/IRQ, raises a forced-BRK
// request, and once the core accepts, sequences the stack pushes and the vector fetch.
`default_nettype none

module int_seq #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = 16'hFFFA,
  parameter logic [15:0] VEC_RST     = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ     = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE  = 8'h01
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_nmi_n,
  input  logic        i_irq_n,
  input  logic        i_pflag_i,
  input  logic        i_start,
  input  logic        i_brk,
  input  logic        i_rdy,
  input  logic [15:0] i_pc,
  input  logic [7:0]  i_p,
  input  logic [7:0]  i_sp,
  input  logic [7:0]  i_rdata,
  output logic        o_int_req,
  output logic        o_busy,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic        o_we,
  output logic        o_re,
  output logic        o_sp_dec,
  output logic        o_set_i,
  output logic [15:0] o_pc,
  output logic        o_pc_load
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_PCH  = 3'd1;
  localparam logic [2:0] c_PCL  = 3'd2;
  localparam logic [2:0] c_PSHP = 3'd3;
  localparam logic [2:0] c_VECL = 3'd4;
  localparam logic [2:0] c_VECH = 3'd5;

  logic [2:0]             state_q, state_d;
  logic                   rst_seq_q, rst_seq_d;
  logic                   brk_q, brk_d;
  logic [15:0]            vec_q, vec_d;
  logic [7:0]             lo_q, lo_d;
  logic [15:0]            pc_q, pc_d;
  logic                   pc_load_q, pc_load_d;
  logic                   nmi_pend_q, nmi_pend_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q;
  logic [SYNC_STAGES-1:0] irq_sync_q;
  logic                   nmi_last_q;

  logic                   nmi_fall;
  logic                   irq_low;
  logic                   nmi_clr;

  assign nmi_fall  = nmi_last_q & ~nmi_sync_q[SYNC_STAGES-1];
  assign irq_low   = ~irq_sync_q[SYNC_STAGES-1];
  assign o_busy    = (state_q != c_IDLE);
  assign o_int_req = ~o_busy & (nmi_pend_q | (irq_low & ~i_pflag_i));
  assign o_pc      = pc_q;
  assign o_pc_load = pc_load_q;

  always_comb begin
    state_d   = state_q;
    rst_seq_d = rst_seq_q;
    brk_d     = brk_q;
    vec_d     = vec_q;
    lo_d      = lo_q;
    pc_d      = pc_q;
    pc_load_d = 1'b0;
    nmi_clr   = 1'b0;
    o_addr    = 16'h0000;
    o_wdata   = 8'h00;
    o_we      = 1'b0;
    o_re      = 1'b0;
    o_sp_dec  = 1'b0;
    o_set_i   = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (i_start) begin
          brk_d   = i_brk;
          state_d = c_PCH;
        end
      end
      c_PCH: begin
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = i_pc[15:8];
        o_we     = i_rdy & ~rst_seq_q;
        o_sp_dec = i_rdy;
        if (i_rdy) state_d = c_PCL;
      end
      c_PCL: begin
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = i_pc[7:0];
        o_we     = i_rdy & ~rst_seq_q;
        o_sp_dec = i_rdy;
        if (i_rdy) state_d = c_PSHP;
      end
      c_PSHP: begin
        // Bit 5 always reads 1 on the stack; bit 4 tells software BRK from hardware.
        o_addr   = {STACK_PAGE, i_sp};
        o_wdata  = (i_p & 8'hEF) | 8'h20 | {3'b000, brk_q, 4'b0000};
        o_we     = i_rdy & ~rst_seq_q;
        o_sp_dec = i_rdy;
        if (i_rdy) begin
          state_d = c_VECL;
          vec_d   = rst_seq_q ? VEC_RST : (nmi_pend_q ? VEC_NMI : VEC_IRQ);
        end
      end
      c_VECL: begin
        o_addr  = vec_q;
        o_re    = 1'b1;
        o_set_i = i_rdy;
        if (i_rdy) begin
          lo_d    = i_rdata;
          nmi_clr = (vec_q == VEC_NMI);
          state_d = c_VECH;
        end
      end
      c_VECH: begin
        o_addr = vec_q + 16'd1;
        o_re   = 1'b1;
        if (i_rdy) begin
          pc_d      = {i_rdata, lo_q};
          pc_load_d = 1'b1;
          rst_seq_d = 1'b0;
          state_d   = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase

    // A fresh NMI edge outranks the acknowledge of the previous one.
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= c_PCH;
      rst_seq_q  <= 1'b1;
      brk_q      <= 1'b0;
      vec_q      <= VEC_RST;
      lo_q       <= 8'h00;
      pc_q       <= 16'h0000;
      pc_load_q  <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
      nmi_last_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rst_seq_q  <= rst_seq_d;
      brk_q      <= brk_d;
      vec_q      <= vec_d;
      lo_q       <= lo_d;
      pc_q       <= pc_d;
      pc_load_q  <= pc_load_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_sync_q <= {nmi_sync_q[SYNC_STAGES-2:0], i_nmi_n};
      irq_sync_q <= {irq_sync_q[SYNC_STAGES-2:0], i_irq_n};
      nmi_last_q <= nmi_sync_q[SYNC_STAGES-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_int_seq.sv
// tb_int_seq: directed scenarios for int_seq with a flat memory model and a core SP model.
`default_nettype none

module tb_int_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_nmi_n = 1'b1;
  logic        i_irq_n = 1'b1;
  logic        i_pflag_i = 1'b1;
  logic        i_start = 1'b0;
  logic        i_brk = 1'b0;
  logic        i_rdy = 1'b1;
  logic [15:0] i_pc = 16'h0000;
  logic [7:0]  i_p = 8'h00;
  logic [7:0]  i_sp = 8'hFD;
  logic [7:0]  i_rdata;
  logic        o_int_req, o_busy, o_we, o_re, o_sp_dec, o_set_i, o_pc_load;
  logic [15:0] o_addr, o_pc;
  logic [7:0]  o_wdata;

  logic [7:0]  mem [0:65535];
  assign i_rdata = mem[o_addr];

  always #5 i_clk = ~i_clk;

  int_seq dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_nmi_n(i_nmi_n), .i_irq_n(i_irq_n),
    .i_pflag_i(i_pflag_i), .i_start(i_start), .i_brk(i_brk), .i_rdy(i_rdy),
    .i_pc(i_pc), .i_p(i_p), .i_sp(i_sp), .i_rdata(i_rdata),
    .o_int_req(o_int_req), .o_busy(o_busy), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_we(o_we), .o_re(o_re), .o_sp_dec(o_sp_dec), .o_set_i(o_set_i),
    .o_pc(o_pc), .o_pc_load(o_pc_load)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] a_addr [16];
  logic [7:0]  a_wdata [16];
  logic [15:0] a_pc [16];
  logic        a_we [16], a_re [16], a_spd [16], a_seti [16], a_pcl [16], a_busy [16], a_req [16];

  // One clock: the core model applies any SP decrement requested in the cycle just ended.
  task automatic step();
    logic d;
    d = o_sp_dec;
    @(posedge i_clk); #1;
    if (d) i_sp = i_sp - 8'd1;
    @(negedge i_clk);
  endtask

  // Records n cycles of outputs; nmi_pin[c] is the NMI pin level driven in cycle c.
  task automatic capture(input int n, input logic [15:0] nmi_pin, input int stall_at, input int stall_len);
    for (int c = 0; c < n; c++) begin
      i_nmi_n = nmi_pin[c];
      i_rdy   = (c >= stall_at && c < stall_at + stall_len) ? 1'b0 : 1'b1;
      #1;
      a_addr[c] = o_addr;  a_wdata[c] = o_wdata; a_pc[c] = o_pc;
      a_we[c]   = o_we;    a_re[c]    = o_re;    a_spd[c] = o_sp_dec;
      a_seti[c] = o_set_i; a_pcl[c]   = o_pc_load;
      a_busy[c] = o_busy;  a_req[c]   = o_int_req;
      step();
    end
    i_rdy = 1'b1;
  endtask

  task automatic start_seq(input logic brk, input logic nmi_pin);
    i_start = 1'b1;
    i_brk   = brk;
    i_nmi_n = nmi_pin;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    int n_spd;
    int n_we;
    repeat (2) @(negedge i_clk);
    #1;
    checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", o_pc); end
    checks++; if ({o_pc_load, o_we, o_re} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b want 000", {o_pc_load, o_we, o_re}); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", o_busy); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    capture(7, 16'hFFFF, 99, 0);
    n_spd = 0; n_we = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_spd[c] === 1'b1) n_spd++;
      if (a_we[c] !== 1'b0) n_we++;
    end
    checks++; if (n_spd != 3) begin errors++; $display("FAIL rst_spdec_count: got %0d want 3", n_spd); end
    checks++; if (n_we != 0) begin errors++; $display("FAIL rst_no_write: got %0d writes want 0", n_we); end
    checks++; if (a_addr[0] !== 16'h01FD) begin errors++; $display("FAIL rst_first_addr: got %h want 01FD", a_addr[0]); end
    checks++; if ({a_addr[3], a_re[3], a_seti[3]} !== {16'hFFFC, 2'b11}) begin errors++; $display("FAIL rst_vecl: got %h re=%b seti=%b want FFFC 1 1", a_addr[3], a_re[3], a_seti[3]); end
    checks++; if (a_addr[4] !== 16'hFFFD) begin errors++; $display("FAIL rst_vech_addr: got %h want FFFD", a_addr[4]); end
    checks++; if ({a_pcl[4], a_pcl[5], a_pcl[6], a_busy[5]} !== 4'b0100) begin errors++; $display("FAIL rst_load_timing: got %b want 0100", {a_pcl[4], a_pcl[5], a_pcl[6], a_busy[5]}); end
    checks++; if (a_pc[5] !== 16'h1234) begin errors++; $display("FAIL rst_vector: got %h want 1234", a_pc[5]); end
  endtask

  task automatic test_irq();
    int w;
    i_sp = 8'hFF; i_pc = 16'hC003; i_p = 8'hA1; i_pflag_i = 1'b0; i_irq_n = 1'b0;
    #1;
    w = 0;
    while (o_int_req !== 1'b1 && w < 10) begin step(); #1; w++; end
    checks++; if (o_int_req !== 1'b1) begin errors++; $display("FAIL irq_req: got %b want 1 within 10 cycles", o_int_req); end
    start_seq(1'b0, 1'b1);
    capture(7, 16'hFFFF, 99, 0);
    checks++; if ({a_we[0], a_addr[0], a_wdata[0]} !== {1'b1, 16'h01FF, 8'hC0}) begin errors++; $display("FAIL irq_push_pch: got %b %h %h want 1 01FF C0", a_we[0], a_addr[0], a_wdata[0]); end
    checks++; if ({a_we[1], a_addr[1], a_wdata[1]} !== {1'b1, 16'h01FE, 8'h03}) begin errors++; $display("FAIL irq_push_pcl: got %b %h %h want 1 01FE 03", a_we[1], a_addr[1], a_wdata[1]); end
    checks++; if ({a_we[2], a_addr[2], a_wdata[2]} !== {1'b1, 16'h01FD, 8'hA1}) begin errors++; $display("FAIL irq_push_p: got %b %h %h want 1 01FD A1", a_we[2], a_addr[2], a_wdata[2]); end
    checks++; if ({a_addr[3], a_re[3], a_seti[3], a_we[3]} !== {16'hFFFE, 3'b110}) begin errors++; $display("FAIL irq_vecl: got %h re=%b seti=%b we=%b want FFFE 1 1 0", a_addr[3], a_re[3], a_seti[3], a_we[3]); end
    checks++; if ({a_addr[4], a_seti[4]} !== {16'hFFFF, 1'b0}) begin errors++; $display("FAIL irq_vech: got %h seti=%b want FFFF 0", a_addr[4], a_seti[4]); end
    checks++; if ({a_pcl[5], a_pc[5]} !== {1'b1, 16'h8000}) begin errors++; $display("FAIL irq_load: got %b %h want 1 8000", a_pcl[5], a_pc[5]); end
    checks++; if (a_req[0] !== 1'b0) begin errors++; $display("FAIL irq_req_busy: got %b want 0", a_req[0]); end
    i_irq_n = 1'b1; i_pflag_i = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_mask();
    int w;
    logic seen;
    i_pflag_i = 1'b1; i_irq_n = 1'b0;
    seen = 1'b0;
    repeat (6) begin step(); #1; if (o_int_req !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mask_irq: got req=1 want 0"); end
    i_nmi_n = 1'b0;
    #1;
    w = 0;
    while (o_int_req !== 1'b1 && w < 10) begin step(); #1; w++; end
    checks++; if (o_int_req !== 1'b1) begin errors++; $display("FAIL mask_nmi_req: got %b want 1 within 10 cycles", o_int_req); end
    i_p = 8'hF4;
    start_seq(1'b0, 1'b0);
    capture(7, 16'h0000, 99, 0);
    checks++; if (a_wdata[2] !== 8'hE4) begin errors++; $display("FAIL nmi_push_p: got %h want E4", a_wdata[2]); end
    checks++; if ({a_addr[3], a_addr[4]} !== {16'hFFFA, 16'hFFFB}) begin errors++; $display("FAIL nmi_vec_addr: got %h %h want FFFA FFFB", a_addr[3], a_addr[4]); end
    checks++; if ({a_pcl[5], a_pc[5]} !== {1'b1, 16'h9000}) begin errors++; $display("FAIL nmi_load: got %b %h want 1 9000", a_pcl[5], a_pc[5]); end
    checks++; if ({a_req[5], a_req[6]} !== 2'b00) begin errors++; $display("FAIL nmi_pend_clear: got %b want 00", {a_req[5], a_req[6]}); end
    i_irq_n = 1'b1; i_nmi_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_brk_hijack();
    i_p = 8'h20; i_pc = 16'h0456; i_pflag_i = 1'b1;
    // Pin falls on the start cycle so the synchronised edge lands in PCL; a second fall lands in VECH.
    start_seq(1'b1, 1'b0);
    capture(7, 16'h0003, 99, 0);
    checks++; if ({a_wdata[0], a_wdata[1]} !== 16'h0456) begin errors++; $display("FAIL brk_push_pc: got %h%h want 0456", a_wdata[0], a_wdata[1]); end
    checks++; if ({a_we[2], a_wdata[2]} !== {1'b1, 8'h30}) begin errors++; $display("FAIL brk_push_p: got %b %h want 1 30", a_we[2], a_wdata[2]); end
    checks++; if (a_addr[3] !== 16'hFFFA) begin errors++; $display("FAIL brk_hijack_vec: got %h want FFFA", a_addr[3]); end
    checks++; if ({a_pc[5], a_busy[5], a_req[5]} !== {16'h9000, 2'b01}) begin errors++; $display("FAIL brk_second_req: got %h busy=%b req=%b want 9000 0 1", a_pc[5], a_busy[5], a_req[5]); end
    start_seq(1'b0, 1'b1);
    capture(7, 16'hFFFF, 99, 0);
    checks++; if ({a_wdata[2], a_addr[3], a_req[5]} !== {8'h20, 16'hFFFA, 1'b0}) begin errors++; $display("FAIL brk_second_serve: got %h %h req=%b want 20 FFFA 0", a_wdata[2], a_addr[3], a_req[5]); end
    repeat (2) step();
  endtask

  task automatic test_collide();
    i_p = 8'h00;
    // Second synchronised edge lands in VECL, the same edge that acknowledges the first.
    start_seq(1'b0, 1'b0);
    capture(7, 16'h0001, 99, 0);
    checks++; if ({a_addr[3], a_req[5]} !== {16'hFFFA, 1'b1}) begin errors++; $display("FAIL collide_set_wins: got %h req=%b want FFFA 1", a_addr[3], a_req[5]); end
    start_seq(1'b0, 1'b1);
    capture(7, 16'hFFFF, 99, 0);
    checks++; if ({a_addr[3], a_req[5]} !== {16'hFFFA, 1'b0}) begin errors++; $display("FAIL collide_drain: got %h req=%b want FFFA 0", a_addr[3], a_req[5]); end
    repeat (2) step();
  endtask

  task automatic test_stall();
    logic bad;
    int n_spd;
    i_sp = 8'hF0; i_pc = 16'hABCD; i_p = 8'h00; i_pflag_i = 1'b1;
    start_seq(1'b1, 1'b1);
    capture(10, 16'hFFFF, 1, 3);
    bad = 1'b0;
    for (int c = 1; c < 4; c++)
      if (a_we[c] !== 1'b0 || a_spd[c] !== 1'b0 || a_addr[c] !== 16'h01EF || a_wdata[c] !== 8'hCD) bad = 1'b1;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL stall_quiet: got we=%b spd=%b addr=%h data=%h want 0 0 01EF CD", a_we[2], a_spd[2], a_addr[2], a_wdata[2]); end
    checks++; if ({a_we[4], a_addr[4], a_wdata[4]} !== {1'b1, 16'h01EF, 8'hCD}) begin errors++; $display("FAIL stall_resume: got %b %h %h want 1 01EF CD", a_we[4], a_addr[4], a_wdata[4]); end
    checks++; if ({a_wdata[5], a_addr[6]} !== {8'h30, 16'hFFFE}) begin errors++; $display("FAIL stall_tail: got %h %h want 30 FFFE", a_wdata[5], a_addr[6]); end
    checks++; if ({a_pcl[7], a_pcl[8], a_pc[8]} !== {2'b01, 16'h8000}) begin errors++; $display("FAIL stall_latency: got %b%b %h want 01 8000", a_pcl[7], a_pcl[8], a_pc[8]); end
    n_spd = 0;
    for (int c = 0; c < 9; c++) if (a_spd[c] === 1'b1) n_spd++;
    checks++; if (n_spd != 3) begin errors++; $display("FAIL stall_spdec_count: got %0d want 3", n_spd); end
    repeat (2) step();
  endtask

  task automatic test_midreset();
    int n_spd;
    int n_we;
    start_seq(1'b1, 1'b1);
    capture(3, 16'hFFFF, 99, 0);
    #1;
    checks++; if ({o_re, o_set_i} !== 2'b11) begin errors++; $display("FAIL mrst_in_vecl: got re=%b seti=%b want 1 1", o_re, o_set_i); end
    i_rst_n = 1'b0;
    #1;
    checks++; if ({o_re, o_we, o_set_i, o_pc_load, o_busy} !== 5'b00001) begin errors++; $display("FAIL mrst_strobes: got %b want 00001", {o_re, o_we, o_set_i, o_pc_load, o_busy}); end
    checks++; if (o_pc !== 16'h0000) begin errors++; $display("FAIL mrst_pc: got %h want 0000", o_pc); end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    i_sp = 8'hFD;
    @(negedge i_clk);
    capture(7, 16'hFFFF, 99, 0);
    n_spd = 0; n_we = 0;
    for (int c = 0; c < 6; c++) begin
      if (a_spd[c] === 1'b1) n_spd++;
      if (a_we[c] !== 1'b0) n_we++;
    end
    checks++; if (n_spd != 3 || n_we != 0) begin errors++; $display("FAIL mrst_flavour: got spdec=%0d writes=%0d want 3 0", n_spd, n_we); end
    checks++; if ({a_addr[3], a_pcl[5], a_pc[5]} !== {16'hFFFC, 1'b1, 16'h1234}) begin errors++; $display("FAIL mrst_vector: got %h %b %h want FFFC 1 1234", a_addr[3], a_pcl[5], a_pc[5]); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    test_reset();
    test_irq();
    test_mask();
    test_brk_hijack();
    test_collide();
    test_stall();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
